// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath selects and enables every cycle, stalling on the memory handshake.
module multicycle_control #(
    parameter int unsigned OPCODE_W    = 6,
    parameter bit          ENABLE_ADDI = 1'b1,
    parameter bit          ENABLE_JUMP = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                illegal,
    output logic                instr_done,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [OPCODE_W-1:0] OpR    = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OpLw   = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OpSw   = OPCODE_W'(43);
    localparam logic [OPCODE_W-1:0] OpBeq  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OpJ    = OPCODE_W'(2);

    state_e state_q, state_d;
    logic   is_store_q, is_store_d;
    logic   op_mem, op_r, op_beq, op_addi, op_j, op_legal;

    // Branch outcome is applied by the datapath; the FSM never looks at zero.
    logic unused_zero;
    assign unused_zero = zero;

    assign op_mem   = (opcode == OpLw) || (opcode == OpSw);
    assign op_r     = (opcode == OpR);
    assign op_beq   = (opcode == OpBeq);
    assign op_addi  = ENABLE_ADDI && (opcode == OpAddi);
    assign op_j     = ENABLE_JUMP && (opcode == OpJ);
    assign op_legal = op_mem || op_r || op_beq || op_addi || op_j;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                // lw/sw choice is captured here so MEMADR does not depend on the IR later.
                is_store_d = (opcode == OpSw);
                if (op_mem)       state_d = StMemAdr;
                else if (op_r)    state_d = StExec;
                else if (op_beq)  state_d = StBranch;
                else if (op_addi) state_d = StAddiEx;
                else if (op_j)    state_d = StJump;
                else              state_d = StFetch;
            end
            StMemAdr: state_d = is_store_q ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
            StJump:   state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'd0;
        PCSource    = 2'd0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        illegal     = 1'b0;
        instr_done  = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            StDecode: begin
                ALUSrcB = 2'd3;
                illegal = !op_legal;
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            StMemRd: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_req    = 1'b1;
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'd2;
            end
            StAluWb: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'd1;
                PCSource    = 2'd1;
                PCWriteCond = 1'b1;
                instr_done  = 1'b1;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            StAddiWb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StJump: begin
                PCSource   = 2'd2;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation MIPS control unit: replaces the single-cycle opcode decoder with a multi-cycle FSM.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over several clocks and drives datapath mux selects and enables each cycle.
- Stalls on a req/ready memory handshake.
- Adds addi and j support, an illegal-opcode flag and an instruction-retire pulse.

Parameters:
- OPCODE_W, 6, opcode field width (IR[31:26]).
- ENABLE_ADDI, 1, when 0 opcode 8 decodes as illegal.
- ENABLE_JUMP, 1, when 0 opcode 2 decodes as illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  OPCODE_W  IR[31:26], sampled in DECODE.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access pending.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  read strobe.
- MemWrite  out  1  write strobe.
- IRWrite  out  1  load IR.
- MemtoReg  out  1  write-back source is MDR.
- RegDst  out  1  destination is rd (1) or rt (0).
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- PCSource  out  2  0 = ALU, 1 = ALUOut, 2 = jump target.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if zero.
- illegal  out  1  one-cycle pulse, unknown opcode.
- instr_done  out  1  one-cycle pulse on the final state of each instruction.
- state  out  4  current state, debug.

Behaviour:
- Opcodes: R=0, lw=35, sw=43, beq=4, addi=8, j=2.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Reset: state=FETCH. Outputs are combinational from state (plus mem_ready/zero). The reset state therefore gives mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00, PCSource=0. All other outputs are 0, including PCWrite and IRWrite (mem_ready is needed for those).
- Any output not listed for a state is 0.
- FETCH: mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00, PCSource=0.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=00. Next state by opcode:
  - lw/sw -> MEMADR
  - R -> EXEC
  - beq -> BRANCH
  - addi -> ADDIEX
  - j -> JUMP
  - any other (or a disabled feature) -> FETCH, with illegal=1 and instr_done=0.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Goes to FETCH.
- MEMWR: mem_req=1, MemWrite=1, IorD=1. Holds until mem_ready.
  - MemWrite stays asserted throughout the hold.
  - On mem_ready: instr_done=1, go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=10. Goes to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCSource=1, PCWriteCond=1, instr_done=1. Goes to FETCH. The PC update is gated externally by zero; the FSM transition is independent of zero.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Goes to FETCH.
- JUMP: PCSource=2, PCWrite=1, instr_done=1. Goes to FETCH.
- Latency with mem_ready tied high, in cycles from FETCH entry to the instr_done cycle inclusive:
  - R = 4, lw = 5, sw = 4, beq = 3, addi = 4, j = 3.
  - Each stalled cycle (mem_ready=0 in FETCH, MEMRD or MEMWR) adds 1.
- Reset mid-instruction, including during a memory stall: next state is FETCH and no write strobe is asserted in the cycle after reset. reset has priority over every transition.
- Unreachable state codes (12-15) go to FETCH.
- mem_ready asserted outside FETCH/MEMRD/MEMWR is ignored.

Test Plan:
- Reset, then opcode=0, mem_ready=1 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7; instr_done pulses at cycle 4.
- opcode=35; mem_ready low 2 cycles in FETCH, then high; low 1 cycle in MEMRD -> states 0,0,0,1,2,3,3,4,0. IRWrite=1 only on cycle 3; MemtoReg=1 in MEMWB.
- opcode=43, mem_ready=1 -> states 0,1,2,5,0. MemWrite=1 and IorD=1 in state 5, RegWrite never 1.
- opcode=4 with zero=1, then with zero=0 -> both sequences 0,1,8,0 with PCWriteCond=1, ALUOp=01, PCSource=1 in state 8. PCWrite stays 0 outside FETCH.
- opcode=8 with ENABLE_ADDI=0; then opcode=63 -> illegal pulses 1 cycle in DECODE, next state 0, instr_done stays 0. With ENABLE_ADDI=1, opcode=8 -> states 0,1,9,10,0.
- reset asserted while held in MEMWR with mem_ready=0 -> next cycle state=0, MemWrite=0, mem_req=1, MemRead=1.
